// File: rtl/mix_columns_engine.sv
// Iterative AES MixColumns / InvMixColumns engine: transforms COLS_PER_CYCLE columns per cycle in place.
// Optional macro MIX_COLUMNS_BYPASS_EN adds in_bypass (IDLE->DONE passthrough for the final round).

module mixColumnLane (
    input  logic [31:0] col,
    input  logic        inv,
    output logic [31:0] mixed
);
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    logic [7:0] a [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];

    // Byte 0 sits in the column MSB.
    for (genvar i = 0; i < 4; i++) begin : gByte
        assign a[i]  = col[31-8*i -: 8];
        assign x2[i] = xtime(a[i]);
        assign x4[i] = xtime(x2[i]);
        assign x8[i] = xtime(x4[i]);
    end

    for (genvar i = 0; i < 4; i++) begin : gRow
        localparam int J1 = (i + 1) % 4;
        localparam int J2 = (i + 2) % 4;
        localparam int J3 = (i + 3) % 4;
        logic [7:0] fwdB, invB;
        assign fwdB = x2[i] ^ (x2[J1] ^ a[J1]) ^ a[J2] ^ a[J3];
        assign invB = (x8[i] ^ x4[i] ^ x2[i])        // 14
                    ^ (x8[J1] ^ x2[J1] ^ a[J1])      // 11
                    ^ (x8[J2] ^ x4[J2] ^ a[J2])      // 13
                    ^ (x8[J3] ^ a[J3]);              // 9
        assign mixed[31-8*i -: 8] = inv ? invB : fwdB;
    end
endmodule

module mix_columns_engine #(
    parameter int NUM_COLS       = 4,
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [32*NUM_COLS-1:0] in_data,
    input  logic                  in_inv,
`ifdef MIX_COLUMNS_BYPASS_EN
    input  logic                  in_bypass,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [32*NUM_COLS-1:0] out_data,
    output logic                  busy
);
    localparam int W  = 32 * NUM_COLS;
    localparam int G  = (COLS_PER_CYCLE > 0) ? NUM_COLS / COLS_PER_CYCLE : 1;
    localparam int CW = (G > 1) ? $clog2(G) : 1;

    if (COLS_PER_CYCLE < 1 || (NUM_COLS % COLS_PER_CYCLE) != 0) begin : gBadCfg
        $error("mix_columns_engine: COLS_PER_CYCLE must divide NUM_COLS");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} engState_e;

    engState_e state, nextState;
    logic [W-1:0]    blockReg;
    logic [CW-1:0]   cnt;
    logic            invMode;
    logic            lastGroup;
    logic            goDone;
    logic [COLS_PER_CYCLE-1:0][31:0] laneIn, laneOut;

    assign lastGroup = (cnt == CW'(G - 1));
    assign out_data  = blockReg;

`ifdef MIX_COLUMNS_BYPASS_EN
    assign goDone = in_bypass;
`else
    assign goDone = 1'b0;
`endif

    always_comb begin
        for (int i = 0; i < COLS_PER_CYCLE; i++)
            laneIn[i] = blockReg[W-1-32*(int'(cnt)*COLS_PER_CYCLE+i) -: 32];
    end

    mixColumnLane uLane [COLS_PER_CYCLE-1:0] (
        .col   (laneIn),
        .inv   (invMode),
        .mixed (laneOut)
    );

    always_comb begin
        nextState = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) nextState = goDone ? DONE : BUSY;
            end
            BUSY: begin
                busy = 1'b1;
                if (lastGroup) nextState = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            blockReg <= '0;
            cnt      <= '0;
            invMode  <= 1'b0;
        end else begin
            state <= nextState;
            case (state)
                IDLE: if (in_valid) begin
                    blockReg <= in_data;
                    invMode  <= in_inv;
                    cnt      <= '0;
                end
                BUSY: begin
                    for (int i = 0; i < COLS_PER_CYCLE; i++)
                        blockReg[W-1-32*(int'(cnt)*COLS_PER_CYCLE+i) -: 32] <= laneOut[i];
                    cnt <= lastGroup ? '0 : cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule
